// File: rtl/psk_pkg.sv
// Shared definitions for the phase-coded chip link (transmitter and correlator).
// Holds the chip count, phase width, default base code, FSM states and chip-index helper.
package psk_pkg;

    localparam int CHIPS   = 6;
    localparam int PHASE_W = 3;

    // Base chip pattern, MSB is chip 0; the correlator side uses the same value.
    localparam logic [CHIPS-1:0] BASE_CODE = 6'b000111;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_ALIGN = 2'd1,
        SEND       = 2'd2,
        GAP        = 2'd3
    } state_e;

    // (k + ph) mod 6 without a divider: both inputs are 0..5, so a single
    // conditional subtract of 6 from the 4-bit sum is enough.
    function automatic logic [PHASE_W-1:0] chip_index(
        input logic [PHASE_W-1:0] k,
        input logic [PHASE_W-1:0] ph
    );
        logic [PHASE_W:0] sum;
        sum = {1'b0, k} + {1'b0, ph};
        if (sum >= 4'd6) begin
            sum = sum - 4'd6;
        end
        return sum[PHASE_W-1:0];
    endfunction

endpackage

// File: rtl/psk_chip_xmit_rotator.sv
// chip_rotator: combinational chip lookup for base code rotated by a phase.
// Ports: chip_cnt (chip slot 0..5), phase (0..5), code (base pattern), chip (selected bit).
module chip_rotator
    import psk_pkg::*;
(
    input  logic [PHASE_W-1:0] chip_cnt,
    input  logic [PHASE_W-1:0] phase,
    input  logic [CHIPS-1:0]   code,
    output logic               chip
);

    logic [PHASE_W-1:0] idx;

    always_comb begin
        idx  = chip_index(chip_cnt, phase);
        // Chip index i lives at code[5-i] because chip 0 is the MSB.
        chip = code[3'(CHIPS - 1) - idx];
    end

endmodule

// File: rtl/psk_chip_xmit.sv
// psk_chip_xmit: sends a 6-chip base code rotated by an accepted phase for a
// hold window, then a guard gap, with chip timing free-running from reset.
// Ports: clk, rst (async, active-high); in_phase/in_valid/in_ready symbol
// handshake; sig registered chip stream; busy while aligning, sending or in
// the gap; err one-cycle pulse for an offered phase of 6 or 7.
module psk_chip_xmit
    import psk_pkg::*;
#(
    parameter logic [CHIPS-1:0] CODE        = BASE_CODE,
    parameter int               HOLD_CYCLES = 48,
    parameter int               GAP_CYCLES  = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-1:0] in_phase,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               sig,
    output logic               busy,
    output logic               err
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  =
        CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [PHASE_W-1:0] CHIP_LAST = PHASE_W'(CHIPS - 1);
    localparam logic [PHASE_W-1:0] PH_MAX    = PHASE_W'(CHIPS - 1);

    state_e             state_q,    state_d;
    logic [PHASE_W-1:0] chip_cnt_q, chip_cnt_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               full_q,     full_d;
    logic [PHASE_W-1:0] hold_ph_q,  hold_ph_d;
    logic [PHASE_W-1:0] act_ph_q,   act_ph_d;
    logic               sig_q,      sig_d;
    logic               err_q,      err_d;

    logic accept;
    logic legal;
    logic aligned;
    logic seek;
    logic load;
    logic rot_chip;

    always_comb begin
        chip_cnt_d = (chip_cnt_q == CHIP_LAST) ? '0 : chip_cnt_q + 3'd1;

        accept  = in_valid && !full_q;
        legal   = (in_phase <= PH_MAX);
        aligned = (chip_cnt_q == CHIP_LAST);

        state_d  = state_q;
        cnt_d    = cnt_q;
        act_ph_d = act_ph_q;
        seek     = 1'b0;
        load     = 1'b0;

        // seek marks cycles where the FSM looks for the next symbol: idle,
        // waiting for alignment, or the final cycle of a symbol/gap.
        unique case (state_q)
            IDLE: begin
                seek = 1'b1;
            end
            WAIT_ALIGN: begin
                seek = 1'b1;
            end
            SEND: begin
                if (cnt_q == HOLD_LAST) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = '0;
                    end else begin
                        seek = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    seek = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase

        // When already on chip 5 the alignment wait is skipped, so a pending
        // symbol follows the previous one with no idle chips in between.
        if (seek) begin
            if (full_q) begin
                if (aligned) begin
                    load = 1'b1;
                end else begin
                    state_d = WAIT_ALIGN;
                end
            end else begin
                state_d = IDLE;
            end
        end

        if (load) begin
            state_d  = SEND;
            cnt_d    = '0;
            act_ph_d = hold_ph_q;
        end

        // accept needs !full_q and load needs full_q, so they never coincide.
        full_d    = full_q;
        hold_ph_d = hold_ph_q;
        if (load) begin
            full_d = 1'b0;
        end else if (accept && legal) begin
            full_d    = 1'b1;
            hold_ph_d = in_phase;
        end

        err_d = accept && !legal;
    end

    // Rotator sees next-state chip slot and phase so the registered chip
    // lands in the same cycle as its chip_cnt value.
    chip_rotator u_rot (
        .chip_cnt (chip_cnt_d),
        .phase    (act_ph_d),
        .code     (CODE),
        .chip     (rot_chip)
    );

    always_comb begin
        sig_d = 1'b0;
        if (state_d == SEND) begin
            sig_d = rot_chip;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            chip_cnt_q <= '0;
            cnt_q      <= '0;
            full_q     <= 1'b0;
            hold_ph_q  <= '0;
            act_ph_q   <= '0;
            sig_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            chip_cnt_q <= chip_cnt_d;
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            hold_ph_q  <= hold_ph_d;
            act_ph_q   <= act_ph_d;
            sig_q      <= sig_d;
            err_q      <= err_d;
        end
    end

    assign in_ready = !full_q;
    assign sig      = sig_q;
    assign busy     = (state_q != IDLE);
    assign err      = err_q;

endmodule

// File: tb/tb_psk_chip_xmit.sv
// Testbench for psk_chip_xmit: schedule-based model plus directed vectors.
// Ports: none (top-level bench).
module tb_psk_chip_xmit;

    localparam int H = 48;
    localparam int G = 12;
    localparam int HN = 8192;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] in_phase = 3'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       sig;
    logic       busy;
    logic       err;

    psk_chip_xmit #(
        .CODE        (6'b000111),
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_phase (in_phase),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sig      (sig),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    logic [5:0] base = 6'b000111;
    int t = 0;
    int n_chk = 0;
    int n_fail = 0;
    int err_at = -1;
    int sym_n[$];
    int sym_s[$];
    int sym_w[$];
    int sym_ph[$];
    logic sig_hist[0:HN-1];
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, t, act, exp);
        end
    endtask

    // Model: each accepted symbol gets a start cycle, the first chip-0 slot
    // after it became pending and after the previous symbol+gap finished.
    function automatic int ceil6(input int x);
        return ((x + 5) / 6) * 6;
    endfunction

    function automatic logic m_ready(input int c);
        foreach (sym_n[i])
            if (sym_n[i] <= c && c < sym_s[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_sig(input int c);
        int idx;
        foreach (sym_s[i]) begin
            if (c >= sym_s[i] && c < sym_s[i] + H) begin
                idx = ((c % 6) + sym_ph[i]) % 6;
                return base[5 - idx];
            end
        end
        return 1'b0;
    endfunction

    function automatic logic m_busy(input int c);
        foreach (sym_s[i])
            if (c >= sym_w[i] && c < sym_s[i] + H + G) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge rst) begin
        sym_n.delete();
        sym_s.delete();
        sym_w.delete();
        sym_ph.delete();
        err_at = -1;
        t = 0;
    end

    initial begin
        int n, pe, w;
        forever begin
            @(posedge clk);
            if (rst) begin
                t = 0;
            end else begin
                if (in_valid && m_ready(t)) begin
                    if (in_phase <= 3'd5) begin
                        n  = t + 1;
                        pe = (sym_s.size() > 0) ? sym_s[$] + H + G : 0;
                        w  = (n + 1 > pe) ? n + 1 : pe;
                        sym_n.push_back(n);
                        sym_w.push_back(w);
                        sym_s.push_back(ceil6(w));
                        sym_ph.push_back(int'(in_phase));
                    end else begin
                        err_at = t + 1;
                    end
                end
                t++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (chk_en) begin
                if (t < HN) sig_hist[t] = sig;
                chk("sig", int'(sig), int'(m_sig(t)));
                chk("busy", int'(busy), int'(m_busy(t)));
                chk("in_ready", int'(in_ready), int'(m_ready(t)));
                chk("err", int'(err), int'(t == err_at));
                chk("chip_cnt", int'(dut.chip_cnt_q), t % 6);
            end
        end
    end

    function automatic int ones(input int a, input int b);
        int c;
        c = 0;
        for (int i = a; i < b; i++)
            if (i >= 0 && i < HN && sig_hist[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int word6(input int s);
        logic [5:0] w;
        w = '0;
        for (int i = 0; i < 6; i++)
            if (s + i >= 0 && s + i < HN) w[5 - i] = sig_hist[s + i];
        return int'(w);
    endfunction

    task automatic send(input int ph, output int acc);
        int k;
        k = 0;
        while (!in_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            chk("send_timeout", 0, 1);
            acc = -1;
            return;
        end
        acc = t;
        in_valid = 1'b1;
        in_phase = 3'(ph);
        @(negedge clk);
        in_valid = 1'b0;
        in_phase = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((busy || !in_ready) && k < 1000);
        if (busy || !in_ready) chk("idle_timeout", 0, 1);
    endtask

    task automatic align(input int k);
        do @(negedge clk); while (t % 6 != k);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog cycle=%0d", t);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b;
        int starts[6];
        logic [11:0] dbl;
        logic [5:0] rot;
        logic [5:0] dec;
        logic ok;

        rst = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_sig", int'(sig), 0);
        chk("rst_ready", int'(in_ready), 1);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_sig", ones(0, 20), 0);

        // Phase 0 offered on chip 2: first chip four cycles later.
        align(2);
        send(0, a);
        wait_idle();
        chk("p0_prealign", ones(a, a + 4), 0);
        chk("p0_word", word6(a + 4), 'b000111);
        chk("p0_word_last", word6(a + 46), 'b000111);
        chk("p0_ones", ones(a + 4, a + 52), 24);
        chk("p0_gap", ones(a + 52, a + 64), 0);

        // Phase 1 then phase 5 back-to-back, no extra alignment wait.
        align(4);
        send(1, a);
        send(5, b);
        wait_idle();
        chk("p1_word", word6(a + 2), 'b001110);
        chk("p1_ones", ones(a + 2, a + 50), 24);
        chk("p15_gap", ones(a + 50, a + 62), 0);
        chk("p5_word", word6(a + 62), 'b100011);
        chk("p5_word_last", word6(a + 104), 'b100011);

        // Illegal phase while ready: one-cycle err, nothing loaded.
        align(1);
        in_valid = 1'b1;
        in_phase = 3'd6;
        @(negedge clk);
        in_valid = 1'b0;
        chk("err_pulse", int'(err), 1);
        chk("err_ready", int'(in_ready), 1);
        chk("err_busy", int'(busy), 0);
        @(negedge clk);
        chk("err_clear", int'(err), 0);
        chk("err_sig", int'(sig), 0);

        // Illegal phase while full: no handshake, so no err.
        send(4, a);
        in_valid = 1'b1;
        in_phase = 3'd7;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("err_notready", int'(err), 0);
        wait_idle();

        // Reset during SEND with a second symbol pending.
        send(2, a);
        send(3, b);
        repeat (10) @(negedge clk);
        chk("pre_rst_busy", int'(busy), 1);
        chk("pre_rst_pending", int'(in_ready), 0);
        rst = 1'b1;
        #1;
        chk("rst_mid_sig", int'(sig), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_ready", int'(in_ready), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        chk("no_resume", ones(0, 80), 0);

        // Loopback through a correlator over all six rotations.
        for (int p = 0; p < 6; p++) begin
            send(p, a);
            starts[p] = sym_s[$];
        end
        wait_idle();
        dbl = {base, base};
        for (int p = 0; p < 6; p++) begin
            dec = '0;
            for (int j = 0; j < 6; j++) begin
                rot = dbl[11 - j -: 6];
                ok = 1'b1;
                for (int c = 0; c < H; c++)
                    if (sig_hist[starts[p] + c] !== rot[5 - (c % 6)]) ok = 1'b0;
                dec[j] = ok;
            end
            chk($sformatf("loop_p%0d", p), int'(dec), 1 << p);
        end

        repeat (4) @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
